// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared state encodings and defaults for the Fibonacci stream checker
package fib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEED  = 2'd1,
    ST_CHECK = 2'd2,
    ST_FAIL  = 2'd3
  } fib_state_e;

  localparam int          DEF_WIDTH = 16;
  localparam int          DEF_CNT_W = 16;
  localparam int unsigned DEF_SEED0 = 0;
  localparam int unsigned DEF_SEED1 = 1;

endpackage

// File: rtl/fib_checker_sat_counter.sv
// rtl/fib_checker_sat_counter.sv - saturating up-counter used for the verified-term count
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset, clears the count
//   clr  - synchronous clear, priority over inc
//   inc  - add one unless already all-ones
//   cnt  - current count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fib_checker.sv
// rtl/fib_checker.sv - checks a Fibonacci sample stream against the modular sum of the previous two terms
//
// Ports:
//   clk, rst      - clock and asynchronous active-low reset
//   en, clr       - sample strobe and synchronous restart (clr wins)
//   din           - sample from the generator
//   expected      - value the next sample must equal
//   match         - one-cycle pulse: last consumed sample checked and correct
//   mismatch      - one-cycle pulse: last consumed sample wrong
//   err           - sticky error, cleared only by clr or reset
//   locked        - high while in CHECK
//   match_cnt     - saturating count of correct samples
//   state         - current FSM state
module fib_checker
  import fib_pkg::*;
#(
  parameter int          WIDTH       = DEF_WIDTH,
  parameter int          CNT_W       = DEF_CNT_W,
  parameter int unsigned SEED0       = DEF_SEED0,
  parameter int unsigned SEED1       = DEF_SEED1,
  parameter bit          CHECK_SEEDS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] expected,
  output logic             match,
  output logic             mismatch,
  output logic             err,
  output logic             locked,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state
);

  localparam logic [WIDTH-1:0] S0 = WIDTH'(SEED0);
  localparam logic [WIDTH-1:0] S1 = WIDTH'(SEED1);
  // With unchecked seeds there is nothing meaningful to predict yet, so show 0.
  localparam logic [WIDTH-1:0] EXP_IDLE = CHECK_SEEDS ? S0 : '0;
  localparam logic [WIDTH-1:0] EXP_SEED = CHECK_SEEDS ? S1 : '0;

  fib_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             match_q, match_d;
  logic             mismatch_q, mismatch_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    exp_d      = exp_q;
    match_d    = 1'b0;
    mismatch_d = 1'b0;
    err_d      = err_q;

    if (clr) begin
      state_d = ST_IDLE;
      a_d     = '0;
      b_d     = '0;
      exp_d   = EXP_IDLE;
      err_d   = 1'b0;
    end else if (en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (CHECK_SEEDS && din != S0) begin
            mismatch_d = 1'b1;
            err_d      = 1'b1;
            state_d    = ST_FAIL;
          end else begin
            match_d = CHECK_SEEDS;
            a_d     = din;
            exp_d   = EXP_SEED;
            state_d = ST_SEED;
          end
        end
        ST_SEED: begin
          if (CHECK_SEEDS && din != S1) begin
            mismatch_d = 1'b1;
            err_d      = 1'b1;
            state_d    = ST_FAIL;
          end else begin
            match_d = CHECK_SEEDS;
            b_d     = din;
            exp_d   = a_q + din;
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (din == exp_q) begin
            match_d = 1'b1;
            a_d     = b_q;
            b_d     = din;
            exp_d   = b_q + din;
          end else begin
            // expected is left untouched so the failing prediction stays visible.
            mismatch_d = 1'b1;
            err_d      = 1'b1;
            state_d    = ST_FAIL;
          end
        end
        default: begin
          state_d = ST_FAIL;
        end
      endcase
    end

    locked_d = (state_d == ST_CHECK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      exp_q      <= EXP_IDLE;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      exp_q      <= exp_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_match_cnt (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .inc(match_d),
    .cnt(match_cnt)
  );

  assign expected = exp_q;
  assign match    = match_q;
  assign mismatch = mismatch_q;
  assign err      = err_q;
  assign locked   = locked_q;
  assign state    = state_q;

endmodule

// File: doc/fib_checker.md
Name: fib_checker

Overview:
Receive-side counterpart to the fib_beh/fib_str Fibonacci generators. It consumes the generator's 16-bit output stream, one sample per enable strobe. It checks that each sample equals the modular sum of the previous two and reports per-sample match/mismatch, a sticky error and a count of verified terms. It sits directly on a generator's out bus, in the same clock domain, so either generator implementation can be self-checked in simulation or on the board.

Parameters:
WIDTH, 16, data width of din/expected; all arithmetic is modulo 2^WIDTH
CNT_W, 16, width of match_cnt; the counter saturates at all-ones
SEED0, 0, required first term
SEED1, 1, required second term
CHECK_SEEDS, 1, 1 = first two samples must equal SEED0/SEED1; 0 = first two samples accepted unchecked as seeds

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-low (0 = reset)
en  in  1  sample strobe; din is consumed on a rising edge where en=1
clr  in  1  synchronous restart; priority over en
din  in  WIDTH  sample from generator
expected  out  WIDTH  value the next sample must equal
match  out  1  one-cycle pulse: last consumed sample was checked and correct
mismatch  out  1  one-cycle pulse: last consumed sample was wrong
err  out  1  sticky error flag
locked  out  1  high in CHECK state
match_cnt  out  CNT_W  number of checked-correct samples, saturating
state  out  2  current FSM state

Behaviour:
- All outputs are registered. A sample consumed at edge k drives match/mismatch high for the clock period following edge k; the pulses are 0 otherwise.
- Reset (rst=0) acts immediately without a clock edge and gives: state=IDLE, err=0, match=0, mismatch=0, match_cnt=0, internal a=b=0, expected=(CHECK_SEEDS ? SEED0 : 0), locked=0.
- clr=1 at an edge produces the same values as reset, synchronously; en is ignored in that cycle.
- en=0 and clr=0: all state holds; pulses are 0.
- States: IDLE=0, SEED=1, CHECK=2, FAIL=3. Encodings live in the package.
- IDLE, en=1:
  - If CHECK_SEEDS and din!=SEED0: mismatch, err<=1, go to FAIL.
  - Otherwise a<=din and go to SEED; expected<=SEED1 (or 0 if CHECK_SEEDS=0).
  - With CHECK_SEEDS=1 a correct seed gives match and count+1. With CHECK_SEEDS=0 neither pulse fires and the count is unchanged.
- SEED, en=1:
  - Same seed check against SEED1.
  - On pass: b<=din, expected<=a+din (mod 2^WIDTH), go to CHECK.
- CHECK, en=1:
  - din==expected: match, count+1 (saturating), a<=b, b<=din, expected<=b+din (mod 2^WIDTH), stay in CHECK.
  - Otherwise: mismatch, err<=1, go to FAIL; expected holds its last value for debug.
- FAIL: en is ignored; the block leaves only on clr or reset. err stays 1 until then.
- Wrap-around: the sum truncates to WIDTH bits, so generators that wrap are accepted. The counter saturates at 2^CNT_W-1 with no wrap.
- locked = (state==CHECK), registered alongside state.
- Simultaneous clr and en: clr wins and the sample is discarded.

Decomposition:
- Package fib_pkg holds: state encodings (ST_IDLE, ST_SEED, ST_CHECK, ST_FAIL), default WIDTH/CNT_W, and default SEED0/SEED1.
- One sub-module, sat_counter (parameter width; inc, clr, async active-low rst), instantiated for match_cnt.
- FSM, seed registers and adder stay in fib_checker.

Test Plan:
- Assert rst=0 mid-clock with no edge -> state=0, err=0, match_cnt=0, expected=0 immediately; release -> values hold.
- en=1 every cycle, din=0,1,1,2,3,5,8 -> seven match pulses, no mismatch; locked from the 3rd cycle; match_cnt=7; expected=13.
- Stream F0..F25, where F24=46368 and F25=9489 (75025 mod 65536) -> all match, match_cnt=26, expected=55857.
- din=0,1,1,2,4 -> mismatch pulse after the 5th sample, err=1, state=3, match_cnt=4; further en samples are ignored; clr=1 -> state=0, err=0, match_cnt=0.
- en toggling every cycle (as the generator bench drives it), with garbage din while en=0 -> only en=1 samples are checked; results are identical to scenario 2. Also: first sample din=5 with CHECK_SEEDS=1 -> immediate mismatch, state=3.
- Drop rst to 0 after samples 0,1,1 -> everything clears asynchronously; release, then 0,1,1,2 -> four matches, match_cnt=4.
